// File: rtl/mult_defs.sv
// Shared definitions for sequential shift-add style datapath blocks:
// FSM state encoding, default operand width and counter sizing helper.
package mult_defs;

  localparam int DEFAULT_N = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  // Width of a step counter that must be able to hold the value n.
  function automatic int step_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/add_nbit.sv
// Ripple-carry adder of configurable width; the only arithmetic element
// used by the shift-add multiplier datapath.
module add_nbit #(
  parameter int Size = 8
) (
  input  logic [Size-1:0] a,
  input  logic [Size-1:0] b,
  input  logic            cin,
  output logic [Size-1:0] sum,
  output logic            cout
);

  logic [Size:0] carry;

  // NOTE: every signal written in always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sum      = '0;
    carry    = '0;
    carry[0] = cin;
    for (int i = 0; i < Size; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout = carry[Size];
  end

endmodule

// File: rtl/mult_shift_add.sv
// Unsigned N x N sequential multiplier: one shift-add step per clock,
// N steps per product, result held on p until the next accepted start.
module mult_shift_add
  import mult_defs::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] p
);

  localparam int CNT_W = step_cnt_w(N);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] STEP_ONE  = CNT_W'(1);

  mult_state_t state;
  mult_state_t next_state;

  logic [N-1:0]     mcand;
  logic [N-1:0]     acc_hi;
  logic [N-1:0]     acc_lo;   // multiplier shifts out as product bits shift in
  logic [CNT_W-1:0] step;

  logic [N-1:0]     addend;
  logic [N-1:0]     sum;
  logic             cout;
  logic             accept;
  logic             last_step;

  assign accept    = (state == IDLE) && start;
  assign last_step = (state == RUN) && (step == LAST_STEP);
  assign addend    = acc_lo[0] ? mcand : '0;

  add_nbit #(
    .Size (N)
  ) u_add (
    .a    (acc_hi),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start)     next_state = RUN;
      RUN:     if (last_step) next_state = DONE;
      DONE:                   next_state = IDLE;
      default:                next_state = IDLE;
    endcase
  end

  // NOTE: operand and accumulator registers are reset explicitly because p must read zero during and after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      step   <= '0;
    end else if (accept) begin
      mcand  <= a;
      acc_hi <= '0;
      acc_lo <= b;
      step   <= '0;
    end else if (state == RUN) begin
      {acc_hi, acc_lo} <= {cout, sum, acc_lo[N-1:1]};
      step             <= step + STEP_ONE;
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign p = {acc_hi, acc_lo};

endmodule

// File: tb/tb_mult_shift_add.sv
// Directed bench for mult_shift_add (N=8): latency, products, ignored
// starts, asynchronous reset and back-to-back operation.
module tb_mult_shift_add;

  localparam int N = 8;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [N-1:0]   a     = '0;
  logic [N-1:0]   b     = '0;
  logic           busy;
  logic           done;
  logic [2*N-1:0] p;

  int n_vec = 0;
  int n_err = 0;

  mult_shift_add #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  always #5 clk = ~clk;

  // Called at a negedge. Edge 1 is the edge that accepts start; the loop
  // samples after each following edge until done (bounded). Optionally
  // scrambles a/b at the given sample index.
  task automatic run_op(input logic [N-1:0] av, input logic [N-1:0] bv,
                        input int change_at, output int done_edge,
                        output int busy_cycles, output logic [2*N-1:0] pv);
    a = av; b = bv; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start       = 1'b0;
    done_edge   = -1;
    busy_cycles = 0;
    pv          = 'x;
    for (int i = 1; i <= 40; i++) begin
      if (i == change_at) begin a = ~av; b = ~bv; end
      if (busy) busy_cycles++;
      if (done) begin done_edge = i; pv = p; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    start = 1'b1; a = 8'd5; b = 8'd6;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_vec++; if (p !== 16'd0) begin n_err++; $display("FAIL reset_p: got %0d want 0", p); end
    repeat (2) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_hold_busy: got %b want 0", busy); end
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_no_start: got busy %b want 0", busy); end
  endtask

  task automatic test_basic();
    int de, bc; logic [2*N-1:0] pv;
    run_op(8'd13, 8'd11, 3, de, bc, pv);
    n_vec++; if (de !== 9) begin n_err++; $display("FAIL basic_done_edge: got %0d want 9", de); end
    n_vec++; if (bc !== 8) begin n_err++; $display("FAIL basic_busy_cycles: got %0d want 8", bc); end
    n_vec++; if (pv !== 16'd143) begin n_err++; $display("FAIL basic_p: got %0d want 143", pv); end
    @(negedge clk);
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_width: got %b want 0", done); end
    repeat (3) @(negedge clk);
    n_vec++; if (p !== 16'd143) begin n_err++; $display("FAIL basic_p_hold: got %0d want 143", p); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_max();
    int de, bc; logic [2*N-1:0] pv;
    run_op(8'd255, 8'd255, 0, de, bc, pv);
    n_vec++; if (de !== 9) begin n_err++; $display("FAIL max_done_edge: got %0d want 9", de); end
    n_vec++; if (pv !== 16'hFE01) begin n_err++; $display("FAIL max_p: got %h want fe01", pv); end
    @(negedge clk);
  endtask

  task automatic test_zero();
    int de, bc; logic [2*N-1:0] pv;
    run_op(8'd0, 8'd200, 0, de, bc, pv);
    n_vec++; if (de !== 9) begin n_err++; $display("FAIL zero_a_done_edge: got %0d want 9", de); end
    n_vec++; if (pv !== 16'd0) begin n_err++; $display("FAIL zero_a_p: got %0d want 0", pv); end
    @(negedge clk);
    run_op(8'd200, 8'd0, 0, de, bc, pv);
    n_vec++; if (de !== 9) begin n_err++; $display("FAIL zero_b_done_edge: got %0d want 9", de); end
    n_vec++; if (bc !== 8) begin n_err++; $display("FAIL zero_b_busy_cycles: got %0d want 8", bc); end
    n_vec++; if (pv !== 16'd0) begin n_err++; $display("FAIL zero_b_p: got %0d want 0", pv); end
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    int pulses = 0;
    logic [2*N-1:0] pv = '0;
    a = 8'd7; b = 8'd9; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      if (i == 3) begin a = 8'd3; b = 8'd3; end
      if (done) begin pulses++; pv = p; end
      // Pulse start once during RUN and once during the DONE cycle.
      start = (i == 3) || done;
      @(negedge clk);
    end
    start = 1'b0;
    n_vec++; if (pulses !== 1) begin n_err++; $display("FAIL ignore_done_pulses: got %0d want 1", pulses); end
    n_vec++; if (pv !== 16'd63) begin n_err++; $display("FAIL ignore_p: got %0d want 63", pv); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ignore_no_new_op: got busy %b want 0", busy); end
    n_vec++; if (p !== 16'd63) begin n_err++; $display("FAIL ignore_p_hold: got %0d want 63", p); end
  endtask

  task automatic test_reset_mid_run();
    int de, bc; logic [2*N-1:0] pv;
    a = 8'd100; b = 8'd100; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL abort_pre_busy: got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL abort_done: got %b want 0", done); end
    n_vec++; if (p !== 16'd0) begin n_err++; $display("FAIL abort_p: got %0d want 0", p); end
    repeat (12) begin
      @(negedge clk);
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL abort_no_done: got %b want 0", done); end
    end
    rst_n = 1'b1;
    run_op(8'd100, 8'd100, 0, de, bc, pv);
    n_vec++; if (de !== 9) begin n_err++; $display("FAIL post_reset_done_edge: got %0d want 9", de); end
    n_vec++; if (pv !== 16'd10000) begin n_err++; $display("FAIL post_reset_p: got %0d want 10000", pv); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [2*N-1:0] exp_p;
    int cyc = 0;
    int last_done = 0;
    int ops = 0;
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    exp_p = a * b;
    start = 1'b1;
    while (ops < 1000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        n_vec++;
        if (p !== exp_p) begin n_err++; $display("FAIL b2b_p op %0d: got %0d want %0d", ops, p, exp_p); end
        if (ops > 0) begin
          n_vec++;
          if (cyc - last_done != 10) begin
            n_err++; $display("FAIL b2b_spacing op %0d: got %0d want 10", ops, cyc - last_done);
          end
        end
        last_done = cyc;
        ops++;
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        exp_p = a * b;
      end
    end
    start = 1'b0;
    n_vec++; if (ops != 1000) begin n_err++; $display("FAIL b2b_timeout: got %0d ops want 1000", ops); end
    repeat (12) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
